// File: rtl/rhythm_game_fsm.sv
// Game-flow controller: menu / song-select / score-view / play screens plus per-song best-score table.
// Optional pause screen enabled by defining RHYTHM_PAUSE_EN.
module rhythm_game_fsm #(
  parameter int NUM_SONGS = 3,
  parameter int SCORE_W   = 10
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   menu_start,
  input  logic                   menu_score,
  input  logic                   back,
  input  logic                   pause,
  input  logic [7:0]             key,
  input  logic [4*NUM_SONGS-1:0] song_notes,
  input  logic [NUM_SONGS-1:0]   song_end,
  input  logic [5:0]             live_rgb,
  input  logic [SCORE_W-1:0]     cur_score,
  output logic [3:0]             lcd_state,
  output logic [5:0]             rgb_sel,
  output logic [3:0]             music_input,
  output logic                   score_en,
  output logic [NUM_SONGS-1:0]   song_start,
  output logic [SCORE_W-1:0]     best_score
);

`ifdef RHYTHM_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SCORE,
    S_PLAY,
    S_PAUSE
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_song_idx, w_song_nxt;
  logic [2:0]           r_view_idx, w_view_nxt;
  logic [7:0]           r_key_q;
  logic                 r_pause_q;
  logic [SCORE_W-1:0]   r_best [NUM_SONGS];

  logic [7:0]           w_edge;
  logic [2:0]           w_key_idx;
  logic                 w_key_vld;
  logic                 w_pause_edge;
  logic                 w_start;
  logic                 w_upd;
  logic                 w_end_cur;
  logic [SCORE_W-1:0]   w_best_cur;
  logic [SCORE_W-1:0]   w_best_view;
  logic [3:0]           w_notes;
  logic [NUM_SONGS-1:0] w_start_nxt;
  logic [3:0]           w_lcd;
  logic [5:0]           w_rgb;
  logic [3:0]           w_music;
  logic                 w_en;

  assign w_edge       = key & ~r_key_q;
  assign w_pause_edge = pause & ~r_pause_q;

  always_comb begin
    w_key_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (w_edge[i]) w_key_idx = 3'(i);
    end
    w_key_vld = (w_edge != 8'd0) && ((w_edge & (w_edge - 8'd1)) == 8'd0)
                && (int'(w_key_idx) < NUM_SONGS);
  end

  always_comb begin
    w_end_cur  = 1'b0;
    w_best_cur = '0;
    for (int unsigned i = 0; i < NUM_SONGS; i++) begin
      if (r_song_idx == 3'(i)) begin
        w_end_cur  = song_end[i];
        w_best_cur = r_best[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_song_nxt  = r_song_idx;
    w_view_nxt  = r_view_idx;
    w_start     = 1'b0;
    w_upd       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (menu_start)      w_state_nxt = S_SELECT;
        else if (menu_score) w_state_nxt = S_SCORE;
      end
      S_SELECT: begin
        if (back) w_state_nxt = S_IDLE;
        else if (w_key_vld) begin
          w_state_nxt = S_PLAY;
          w_song_nxt  = w_key_idx;
          w_start     = 1'b1;
        end
      end
      S_SCORE: begin
        if (back)           w_state_nxt = S_IDLE;
        else if (w_key_vld) w_view_nxt  = w_key_idx;
      end
      S_PLAY: begin
        if (back) w_state_nxt = S_SELECT;
        else if (w_end_cur) begin
          w_state_nxt = S_SELECT;
          w_upd       = (cur_score > w_best_cur);
        end else if (PAUSE_EN && w_pause_edge) w_state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (back)              w_state_nxt = S_SELECT;
        else if (w_pause_edge) w_state_nxt = S_PLAY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs are derived from next-state values so they change on the same edge as the state.
  always_comb begin
    w_notes     = 4'd14;
    w_best_view = '0;
    w_start_nxt = '0;
    for (int unsigned i = 0; i < NUM_SONGS; i++) begin
      if (w_song_nxt == 3'(i)) w_notes = song_notes[4*i +: 4];
      if (w_view_nxt == 3'(i))
        w_best_view = (w_upd && r_song_idx == 3'(i)) ? cur_score : r_best[i];
      if (w_start && w_key_idx == 3'(i)) w_start_nxt[i] = 1'b1;
    end
  end

  always_comb begin
    w_lcd   = 4'd0;
    w_rgb   = 6'b100000;
    w_music = 4'd14;
    w_en    = 1'b0;
    case (w_state_nxt)
      S_SELECT: begin
        w_lcd = 4'd1;
        w_rgb = 6'b001000;
      end
      S_SCORE: begin
        w_lcd = 4'd2;
        w_rgb = 6'b000010;
      end
      S_PLAY: begin
        w_lcd   = 4'd3 + {1'b0, w_song_nxt};
        w_rgb   = live_rgb;
        w_music = w_notes;
        w_en    = 1'b1;
      end
      S_PAUSE: begin
        w_lcd = 4'hF;
        w_rgb = 6'b101000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state     <= S_IDLE;
      r_song_idx  <= '0;
      r_view_idx  <= '0;
      r_key_q     <= '0;
      r_pause_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_SONGS; i++) r_best[i] <= '0;
      lcd_state   <= 4'd0;
      rgb_sel     <= 6'b100000;
      music_input <= 4'd14;
      score_en    <= 1'b0;
      song_start  <= '0;
      best_score  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_song_idx  <= w_song_nxt;
      r_view_idx  <= w_view_nxt;
      r_key_q     <= key;
      r_pause_q   <= pause;
      for (int unsigned i = 0; i < NUM_SONGS; i++) begin
        if (w_upd && r_song_idx == 3'(i)) r_best[i] <= cur_score;
      end
      lcd_state   <= w_lcd;
      rgb_sel     <= w_rgb;
      music_input <= w_music;
      score_en    <= w_en;
      song_start  <= w_start_nxt;
      best_score  <= w_best_view;
    end
  end

endmodule
